// File: rtl/writeback_sequencer_pkg.sv
// rtl/writeback_sequencer_pkg.sv - processor-wide register-file constants and writeback entry types
package writeback_sequencer_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  localparam logic [REG_W-1:0] REG_LR = 4'd14;
  localparam logic [REG_W-1:0] REG_PC = 4'd15;

  typedef enum logic {
    S_IDLE,
    S_DEST
  } state_t;

  // Metadata (enable, link, dest) sits in the top bits so the FIFO can expose it cheaply.
  typedef struct packed {
    logic              enable;
    logic              link;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] lr;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);
  localparam int META_W  = 2 + REG_W;

endpackage

// File: rtl/writeback_sequencer_fifo.sv
// rtl/writeback_sequencer_fifo.sv - wb_fifo: circular buffer with per-slot metadata view
module wb_fifo #(
  parameter int DEPTH  = 2,
  parameter int WIDTH  = 70,
  parameter int META_W = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_flush,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_head,
  output logic                           o_empty,
  output logic [$clog2(DEPTH):0]         o_count,
  output logic [DEPTH-1:0][META_W-1:0]   o_meta,
  output logic [DEPTH-1:0]               o_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;

  assign o_head  = r_mem[r_rd];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PTR_W-1:0] w_off;
    assign w_off      = PTR_W'(g) - r_rd;
    assign o_valid[g] = ({1'b0, w_off} < r_count);
    assign o_meta[g]  = r_mem[g][WIDTH-1 -: META_W];
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PTR_W'(1);
      if (i_pop)  r_rd <= r_rd + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_sequencer.sv
// rtl/writeback_sequencer.sv - buffers retired results and drives the register-file write port
module writeback_sequencer
  import writeback_sequencer_pkg::*;
#(
  parameter int          DEPTH       = 2,
  parameter logic [31:0] LINK_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbValid,
  output logic        wbReady,
  input  logic        wbEnable,
  input  logic        wbLink,
  input  logic [3:0]  wbDest,
  input  logic [31:0] wbData,
  input  logic [31:0] wbPC,
  input  logic        flush,
  output logic        writeEnable,
  output logic [3:0]  writeDestination,
  output logic [31:0] writeData,
  output logic        pcWrite,
  output logic [31:0] pcWriteData,
  output logic [15:0] pendingMask,
  output logic        busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [REG_W-1:0]            r_held_dest;
  logic [DATA_W-1:0]           r_held_data;

  wb_entry_t                   w_push_entry;
  wb_entry_t                   w_head;
  logic [ENTRY_W-1:0]          w_head_bits;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_empty;
  logic [CNT_W-1:0]            w_count;
  logic [DEPTH-1:0][META_W-1:0] w_meta;
  logic [DEPTH-1:0]            w_valid;

  logic                        w_load_held;
  logic                        w_we;
  logic [REG_W-1:0]            w_dest;
  logic [DATA_W-1:0]           w_data;

  assign wbReady = (w_count < CNT_W'(DEPTH));
  // Bubbles (no enable, no link) are acknowledged but never occupy a slot.
  assign w_push  = wbValid && wbReady && !flush && (wbEnable || wbLink);
  assign busy    = !w_empty || (r_state != S_IDLE);

  assign w_push_entry = '{enable: wbEnable, link: wbLink, dest: wbDest,
                          data: wbData, lr: wbPC + LINK_OFFSET};
  assign w_head       = w_head_bits;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .WIDTH  (ENTRY_W),
    .META_W (META_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head_bits),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_meta  (w_meta),
    .o_valid (w_valid)
  );

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_load_held  = 1'b0;
    w_we         = 1'b0;
    w_dest       = '0;
    w_data       = '0;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            w_pop = 1'b1;
            w_we  = 1'b1;
            if (w_head.link) begin
              w_dest = REG_LR;
              w_data = w_head.lr;
              if (w_head.enable) begin
                w_load_held  = 1'b1;
                w_next_state = S_DEST;
              end
            end else begin
              w_dest = w_head.dest;
              w_data = w_head.data;
            end
          end
        end
        S_DEST: begin
          w_we         = 1'b1;
          w_dest       = r_held_dest;
          w_data       = r_held_data;
          w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_held_dest      <= '0;
      r_held_data      <= '0;
      writeEnable      <= 1'b0;
      writeDestination <= '0;
      writeData        <= '0;
      pcWrite          <= 1'b0;
      pcWriteData      <= '0;
    end else begin
      r_state          <= w_next_state;
      if (w_load_held) begin
        r_held_dest <= w_head.dest;
        r_held_data <= w_head.data;
      end
      writeEnable      <= w_we;
      writeDestination <= w_dest;
      writeData        <= w_data;
      pcWrite          <= w_we && (w_dest == REG_PC);
      pcWriteData      <= (w_we && (w_dest == REG_PC)) ? w_data : '0;
    end
  end

  // The held DEST half still counts as pending until its write issues.
  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && w_meta[i][META_W-1]) pendingMask[w_meta[i][REG_W-1:0]] = 1'b1;
      if (w_valid[i] && w_meta[i][META_W-2]) pendingMask[REG_LR] = 1'b1;
    end
    if (r_state == S_DEST) pendingMask[r_held_dest] = 1'b1;
  end

endmodule

// File: tb/tb_writeback_sequencer.sv
// tb/tb_writeback_sequencer.sv - scoreboard bench for writeback_sequencer
module tb_writeback_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wbValid = 1'b0;
  logic        wbReady;
  logic        wbEnable = 1'b0;
  logic        wbLink = 1'b0;
  logic [3:0]  wbDest = '0;
  logic [31:0] wbData = '0;
  logic [31:0] wbPC = '0;
  logic        flush = 1'b0;
  logic        writeEnable;
  logic [3:0]  writeDestination;
  logic [31:0] writeData;
  logic        pcWrite;
  logic [31:0] pcWriteData;
  logic [15:0] pendingMask;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] data;
    logic        pcw;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  writeback_sequencer #(
    .DEPTH       (2),
    .LINK_OFFSET (32'd4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wbValid          (wbValid),
    .wbReady          (wbReady),
    .wbEnable         (wbEnable),
    .wbLink           (wbLink),
    .wbDest           (wbDest),
    .wbData           (wbData),
    .wbPC             (wbPC),
    .flush            (flush),
    .writeEnable      (writeEnable),
    .writeDestination (writeDestination),
    .writeData        (writeData),
    .pcWrite          (pcWrite),
    .pcWriteData      (pcWriteData),
    .pendingMask      (pendingMask),
    .busy             (busy)
  );

  // Scoreboard: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (writeEnable === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_write got dest=%0d data=%h want no write", writeDestination, writeData);
        end else begin
          e = exp_q.pop_front();
          if (writeDestination !== e.dest || writeData !== e.data || pcWrite !== e.pcw ||
              (e.pcw && pcWriteData !== e.data))
            $display("FAIL sb_write got dest=%0d data=%h pcw=%b pcwd=%h want dest=%0d data=%h pcw=%b",
                     writeDestination, writeData, pcWrite, pcWriteData, e.dest, e.data, e.pcw);
          else
            n_pass++;
        end
      end else if (pcWrite !== 1'b0) begin
        n_checks++;
        $display("FAIL sb_pcwrite_alone got pcWrite=%b want 0", pcWrite);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic offer(input logic en, input logic lk, input logic [3:0] d,
                       input logic [31:0] dat, input logic [31:0] pc);
    int n;
    exp_t e;
    n = 0;
    wbValid = 1'b1; wbEnable = en; wbLink = lk; wbDest = d; wbData = dat; wbPC = pc;
    while (wbReady !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      n_checks++;
      $display("FAIL offer_timeout got wbReady=%b want 1 within 50 cycles", wbReady);
    end else begin
      @(posedge clk);
      if (lk) begin e.dest = 4'd14; e.data = pc + 32'd4; e.pcw = 1'b0; exp_q.push_back(e); end
      if (en) begin e.dest = d; e.data = dat; e.pcw = (d == 4'd15); exp_q.push_back(e); end
      #1;
    end
    wbValid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({writeEnable, pcWrite, busy, pendingMask, writeDestination, writeData, pcWriteData} !== '0)
      $display("FAIL reset_outputs got we=%b pcw=%b busy=%b mask=%h dest=%0d data=%h pcwd=%h want all 0",
               writeEnable, pcWrite, busy, pendingMask, writeDestination, writeData, pcWriteData);
    else n_pass++;
    n_checks++;
    if (wbReady !== 1'b1) $display("FAIL reset_ready got %b want 1", wbReady); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || wbReady !== 1'b1)
      $display("FAIL reset_release got busy=%b ready=%b want 0/1", busy, wbReady);
    else n_pass++;
  endtask

  task automatic test_single;
    n_checks++;
    if (wbReady !== 1'b1) $display("FAIL single_ready got %b want 1", wbReady); else n_pass++;
    offer(1'b1, 1'b0, 4'd3, 32'hAAAAAAAA, 32'h0);
    n_checks++;
    if (pendingMask !== 16'h0008 || writeEnable !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_queued got mask=%h we=%b busy=%b want 0008/0/1", pendingMask, writeEnable, busy);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (writeEnable !== 1'b1 || writeDestination !== 4'd3 || pendingMask !== 16'h0)
      $display("FAIL single_issue got we=%b dest=%0d mask=%h want 1/3/0000", writeEnable, writeDestination, pendingMask);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (writeEnable !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_done got we=%b busy=%b want 0/0", writeEnable, busy);
    else n_pass++;
  endtask

  task automatic test_bl;
    offer(1'b1, 1'b1, 4'd15, 32'h100, 32'h40);
    n_checks++;
    if (pendingMask !== 16'hC000) $display("FAIL bl_mask_queued got %h want c000", pendingMask); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (writeDestination !== 4'd14 || writeData !== 32'h44 || pcWrite !== 1'b0 || pendingMask !== 16'h8000)
      $display("FAIL bl_lr got dest=%0d data=%h pcw=%b mask=%h want 14/44/0/8000",
               writeDestination, writeData, pcWrite, pendingMask);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (writeDestination !== 4'd15 || pcWrite !== 1'b1 || pcWriteData !== 32'h100 || pendingMask !== 16'h0)
      $display("FAIL bl_dest got dest=%0d pcw=%b pcwd=%h mask=%h want 15/1/100/0000",
               writeDestination, pcWrite, pcWriteData, pendingMask);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL bl_idle got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_pressure;
    exp_t e;
    offer(1'b1, 1'b1, 4'd1, 32'h11, 32'h100);
    offer(1'b1, 1'b1, 4'd2, 32'h22, 32'h200);
    offer(1'b1, 1'b0, 4'd5, 32'h55, 32'h0);
    n_checks++;
    if (wbReady !== 1'b0 || busy !== 1'b1 || pendingMask !== 16'h4024)
      $display("FAIL bp_full got ready=%b busy=%b mask=%h want 0/1/4024", wbReady, busy, pendingMask);
    else n_pass++;
    wbValid = 1'b1; wbEnable = 1'b1; wbLink = 1'b0; wbDest = 4'd6; wbData = 32'h66;
    @(posedge clk); #1;
    n_checks++;
    if (wbReady !== 1'b1 || pendingMask !== 16'h0024)
      $display("FAIL bp_after_pop got ready=%b mask=%h want 1/0024", wbReady, pendingMask);
    else n_pass++;
    @(posedge clk);
    e.dest = 4'd6; e.data = 32'h66; e.pcw = 1'b0; exp_q.push_back(e);
    #1;
    wbValid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL bp_drain got left=%0d busy=%b want 0/0", exp_q.size(), busy);
    else n_pass++;
  endtask

  task automatic test_flush_mid_bl;
    offer(1'b1, 1'b1, 4'd7, 32'h77, 32'h100);
    @(posedge clk); #1;
    n_checks++;
    if (writeEnable !== 1'b1 || writeDestination !== 4'd14 || writeData !== 32'h104)
      $display("FAIL flush_lr got we=%b dest=%0d data=%h want 1/14/104", writeEnable, writeDestination, writeData);
    else n_pass++;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    n_checks++;
    if (writeEnable !== 1'b0 || pendingMask !== 16'h0 || busy !== 1'b0 || wbReady !== 1'b1)
      $display("FAIL flush_clear got we=%b mask=%h busy=%b ready=%b want 0/0000/0/1",
               writeEnable, pendingMask, busy, wbReady);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_bubble_r14;
    offer(1'b0, 1'b0, 4'd9, 32'hDEAD, 32'h0);
    n_checks++;
    if (busy !== 1'b0 || pendingMask !== 16'h0)
      $display("FAIL bubble_ignored got busy=%b mask=%h want 0/0000", busy, pendingMask);
    else n_pass++;
    offer(1'b1, 1'b1, 4'd14, 32'h7, 32'h40);
    n_checks++;
    if (pendingMask !== 16'h4000) $display("FAIL r14_mask_queued got %h want 4000", pendingMask); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (writeData !== 32'h44 || pendingMask !== 16'h4000)
      $display("FAIL r14_first got data=%h mask=%h want 44/4000", writeData, pendingMask);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (writeDestination !== 4'd14 || writeData !== 32'h7 || pendingMask !== 16'h0)
      $display("FAIL r14_second got dest=%0d data=%h mask=%h want 14/7/0000", writeDestination, writeData, pendingMask);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset;
    offer(1'b1, 1'b1, 4'd1, 32'h11, 32'h0);
    offer(1'b1, 1'b1, 4'd2, 32'h22, 32'h8);
    offer(1'b1, 1'b0, 4'd15, 32'h33, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    n_checks++;
    if ({writeEnable, pcWrite, busy, pendingMask, writeDestination, writeData, pcWriteData} !== '0)
      $display("FAIL async_reset got we=%b pcw=%b busy=%b mask=%h dest=%0d data=%h pcwd=%h want all 0",
               writeEnable, pcWrite, busy, pendingMask, writeDestination, writeData, pcWriteData);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (wbReady !== 1'b1 || busy !== 1'b0)
      $display("FAIL async_release got ready=%b busy=%b want 1/0", wbReady, busy);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_bl();
    test_back_pressure();
    test_flush_mid_bl();
    test_bubble_r14();
    test_async_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover got %0d want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
